// File: rtl/sr_drive_sequencer.sv
// Drives an SR flip-flop to a requested Q value using excitation pulses,
// confirms the change through q_fb with a timeout, and reports done/err.
module sr_drive_sequencer #(
  parameter int unsigned PULSE_W = 1,
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_bit,
  output logic             S,
  output logic             R,
  input  logic             q_fb,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned PCW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam int unsigned TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PCW-1:0] PLAST = PCW'(PULSE_W - 1);
  localparam logic [TCW-1:0] TLAST = TCW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    VERIFY,
    DONE,
    ERR
  } state_t;

  state_t             state, state_n;
  logic               target, target_n;
  logic [PCW-1:0]     pcnt, pcnt_n;
  logic [TCW-1:0]     tcnt, tcnt_n;
  logic               s_n, r_n, done_n, err_n;
  logic [CNT_W-1:0]   ecnt_n;

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      target    <= 1'b0;
      pcnt      <= '0;
      tcnt      <= '0;
      S         <= 1'b0;
      R         <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      target    <= target_n;
      pcnt      <= pcnt_n;
      tcnt      <= tcnt_n;
      S         <= s_n;
      R         <= r_n;
      done      <= done_n;
      err       <= err_n;
      err_count <= ecnt_n;
    end
  end

  // Outputs are computed for the state being entered so they are registered
  // yet line up with that state's cycle.
  always_comb begin
    state_n  = state;
    target_n = target;
    pcnt_n   = pcnt;
    tcnt_n   = tcnt;
    s_n      = 1'b0;
    r_n      = 1'b0;
    done_n   = 1'b0;
    err_n    = 1'b0;
    ecnt_n   = err_count;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          target_n = req_bit;
          if (q_fb == req_bit) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = DRIVE;
            pcnt_n  = '0;
            s_n     = req_bit;
            r_n     = ~req_bit;
          end
        end
      end
      DRIVE: begin
        if (pcnt == PLAST) begin
          state_n = VERIFY;
          tcnt_n  = '0;
        end else begin
          pcnt_n = pcnt + 1'b1;
          s_n    = S;
          r_n    = R;
        end
      end
      VERIFY: begin
        if (q_fb == target) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else if (tcnt == TLAST) begin
          state_n = ERR;
          err_n   = 1'b1;
          if (err_count != '1) ecnt_n = err_count + 1'b1;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule
